// File: rtl/queue_elrm_pkg.sv
// Shared helpers for the element rate-match queue: modulo add, min and width derivation.
package queue_elrm_pkg;

    // Single conditional subtract; requires val0 < mod and val1 <= mod.
    function automatic int unsigned mod_add(input int unsigned val0, input int unsigned val1,
                                            input int unsigned mod);
        int unsigned sum;
        sum = val0 + val1;
        return (sum >= mod) ? sum - mod : sum;
    endfunction

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    // Pointer width, floored at 1 bit so a depth of 1 still yields a legal vector.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width able to hold the values 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/queue_elrm_ptr.sv
// Modulo-DEPTH pointer register advanced by a variable amount each cycle, with synchronous init.
module queue_elrm_ptr
    import queue_elrm_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PW    = 3,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          init_i,
    input  logic [AW-1:0] adv_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = PW'(mod_add(32'(ptr_q), 32'(adv_i), DEPTH));
        if (init_i) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/queue_elrm_pc.sv
// Element rate-match queue with partial-acceptance handshakes and registered status.
// Optional protocol clamping/error flags enabled by defining QUEUE_ELRM_PC_PROTCHK_EN.
module queue_elrm_pc
    import queue_elrm_pkg::*;
#(
    parameter type         ET          = logic [31:0],
    parameter int unsigned FIFO_NENTRY = 8,
    parameter int unsigned IW_NENTRY   = 2,
    parameter int unsigned OW_NENTRY   = 2,
    parameter int unsigned AF_THRESH   = FIFO_NENTRY - 1,
    localparam int unsigned CNTW       = cnt_w(FIFO_NENTRY),
    localparam int unsigned IWCW       = cnt_w(IW_NENTRY),
    localparam int unsigned OWCW       = cnt_w(OW_NENTRY)
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            init,
    input  logic            din_val,
    input  logic [IWCW-1:0] din_val_cnt,
    output logic            din_rdy,
    output logic [IWCW-1:0] din_rdy_cnt,
    input  ET               din [0:IW_NENTRY-1],
    output logic            dout_val,
    output logic [OWCW-1:0] dout_val_cnt,
    input  logic            dout_rdy,
    input  logic [OWCW-1:0] dout_rdy_cnt,
    output ET               dout [0:OW_NENTRY-1],
    output logic [CNTW-1:0] count,
    output logic [CNTW-1:0] free,
    output logic            almost_full,
    output logic            err_ovf,
    output logic            err_udf
);

    localparam int unsigned PTRW = ptr_w(FIFO_NENTRY);
    localparam int unsigned NCW  = CNTW + 1;

    ET               mem_q [0:FIFO_NENTRY-1];
    logic [PTRW-1:0] widx;
    logic [PTRW-1:0] ridx;
    logic [PTRW-1:0] waddr [0:IW_NENTRY-1];

    logic [IWCW-1:0] raw_in, acc_in;
    logic [OWCW-1:0] raw_out, acc_out;
    logic [NCW-1:0]  ncount;

    logic            din_rdy_q, din_rdy_d;
    logic [IWCW-1:0] din_rdy_cnt_q, din_rdy_cnt_d;
    logic            dout_val_q, dout_val_d;
    logic [OWCW-1:0] dout_val_cnt_q, dout_val_cnt_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [CNTW-1:0] free_q, free_d;
    logic            almost_full_q, almost_full_d;

`ifdef QUEUE_ELRM_PC_PROTCHK_EN
    logic err_ovf_q, err_ovf_d;
    logic err_udf_q, err_udf_d;
`endif

    // Accepted counts, next occupancy and next status registers.
    always_comb begin
        raw_in  = (din_val && din_rdy_q) ? din_val_cnt : '0;
        raw_out = (dout_val_q && dout_rdy) ? dout_rdy_cnt : '0;
        acc_in  = raw_in;
        acc_out = raw_out;
`ifdef QUEUE_ELRM_PC_PROTCHK_EN
        err_ovf_d = err_ovf_q;
        err_udf_d = err_udf_q;
        if (raw_in > din_rdy_cnt_q) begin
            acc_in    = din_rdy_cnt_q;
            err_ovf_d = 1'b1;
        end
        if (raw_out > dout_val_cnt_q) begin
            acc_out   = dout_val_cnt_q;
            err_udf_d = 1'b1;
        end
`endif
        ncount = NCW'(count_q) + NCW'(acc_in) - NCW'(acc_out);

        count_d        = CNTW'(ncount);
        free_d         = CNTW'(FIFO_NENTRY - 32'(ncount));
        din_rdy_cnt_d  = IWCW'(min_u(FIFO_NENTRY - 32'(ncount), IW_NENTRY));
        din_rdy_d      = (din_rdy_cnt_d != '0);
        dout_val_cnt_d = OWCW'(min_u(32'(ncount), OW_NENTRY));
        dout_val_d     = (ncount != '0);
        almost_full_d  = (32'(ncount) >= AF_THRESH);

        // init discards this cycle's transfers and restores the reset state.
        if (init) begin
            count_d        = '0;
            free_d         = CNTW'(FIFO_NENTRY);
            din_rdy_cnt_d  = IWCW'(IW_NENTRY);
            din_rdy_d      = 1'b1;
            dout_val_cnt_d = '0;
            dout_val_d     = 1'b0;
            almost_full_d  = (AF_THRESH == 0);
`ifdef QUEUE_ELRM_PC_PROTCHK_EN
            err_ovf_d      = 1'b0;
            err_udf_d      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count_q        <= '0;
            free_q         <= CNTW'(FIFO_NENTRY);
            din_rdy_cnt_q  <= IWCW'(IW_NENTRY);
            din_rdy_q      <= 1'b1;
            dout_val_cnt_q <= '0;
            dout_val_q     <= 1'b0;
            almost_full_q  <= (AF_THRESH == 0);
        end else begin
            count_q        <= count_d;
            free_q         <= free_d;
            din_rdy_cnt_q  <= din_rdy_cnt_d;
            din_rdy_q      <= din_rdy_d;
            dout_val_cnt_q <= dout_val_cnt_d;
            dout_val_q     <= dout_val_d;
            almost_full_q  <= almost_full_d;
        end
    end

`ifdef QUEUE_ELRM_PC_PROTCHK_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`else
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif

    queue_elrm_ptr #(
        .DEPTH (FIFO_NENTRY),
        .PW    (PTRW),
        .AW    (IWCW)
    ) u_wptr (
        .clk    (clk),
        .arst_n (arst_n),
        .init_i (init),
        .adv_i  (acc_in),
        .ptr_o  (widx)
    );

    queue_elrm_ptr #(
        .DEPTH (FIFO_NENTRY),
        .PW    (PTRW),
        .AW    (OWCW)
    ) u_rptr (
        .clk    (clk),
        .arst_n (arst_n),
        .init_i (init),
        .adv_i  (acc_out),
        .ptr_o  (ridx)
    );

    always_comb begin
        for (int unsigned i = 0; i < IW_NENTRY; i++) begin
            waddr[i] = PTRW'(mod_add(32'(widx), i, FIFO_NENTRY));
        end
    end

    // Storage is not reset; occupancy alone qualifies its contents.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < IW_NENTRY; i++) begin
            if (!init && (i < 32'(acc_in))) begin
                mem_q[waddr[i]] <= din[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < OW_NENTRY; i++) begin
            dout[i] = mem_q[PTRW'(mod_add(32'(ridx), i, FIFO_NENTRY))];
        end
    end

    assign din_rdy      = din_rdy_q;
    assign din_rdy_cnt  = din_rdy_cnt_q;
    assign dout_val     = dout_val_q;
    assign dout_val_cnt = dout_val_cnt_q;
    assign count        = count_q;
    assign free         = free_q;
    assign almost_full  = almost_full_q;

endmodule
